// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per load/store, with byte-lane steering and load extension.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses complete at once with out_err, no bus request.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        stall_req,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0]    a_lo;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          access_c;
  logic          misalign_c;
  logic          timeout_c;
  logic          err_c;
  logic [31:0]   wdata_c;
  logic [3:0]    wstrb_c;
  logic [31:0]   sh_c;
  logic [31:0]   ext_c;

  assign access_c  = in_ren | in_wen;
  assign timeout_c = (cnt == CW'(TIMEOUT - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = ((in_size == 2'd1) && in_addr[0]) ||
                      (in_size[1] && (in_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane replication and byte strobes for the incoming instruction
  always_comb begin
    wdata_c = in_wdata;
    wstrb_c = 4'hF;
    case (in_size)
      2'd0: begin
        wdata_c = {4{in_wdata[7:0]}};
        wstrb_c = 4'b0001 << in_addr[1:0];
      end
      2'd1: begin
        wdata_c = {2{in_wdata[15:0]}};
        wstrb_c = 4'b0011 << {in_addr[1], 1'b0};
      end
      default: begin
        wdata_c = in_wdata;
        wstrb_c = 4'hF;
      end
    endcase
    if (!in_wen) wstrb_c = 4'h0;
  end

  // Load lane extraction and sign/zero extension from the captured access
  always_comb begin
    sh_c  = bus_rsp_rdata;
    ext_c = bus_rsp_rdata;
    case (size_q)
      2'd0: begin
        sh_c  = bus_rsp_rdata >> {a_lo, 3'b000};
        ext_c = uns_q ? {24'b0, sh_c[7:0]} : {{24{sh_c[7]}}, sh_c[7:0]};
      end
      2'd1: begin
        sh_c  = bus_rsp_rdata >> {a_lo[1], 4'b0000};
        ext_c = uns_q ? {16'b0, sh_c[15:0]} : {{16{sh_c[15]}}, sh_c[15:0]};
      end
      default: begin
        sh_c  = bus_rsp_rdata;
        ext_c = bus_rsp_rdata;
      end
    endcase
  end

  // Next-state, stall and completion-error decode
  always_comb begin
    state_n   = state;
    stall_req = 1'b0;
    err_c     = 1'b0;
    case (state)
      IDLE: begin
        if (access_c) begin
          stall_req = 1'b1;
          if (misalign_c) begin
            state_n = DONE;
            err_c   = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        stall_req = 1'b1;
        if (timeout_c) begin
          state_n = DONE;
          err_c   = 1'b1;
        end else if (bus_req_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        stall_req = 1'b1;
        if (bus_rsp_valid) begin
          state_n = DONE;
        end else if (timeout_c) begin
          state_n = DONE;
          err_c   = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
      a_lo          <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      out_valid     <= 1'b0;
      out_err       <= 1'b0;
      out_rdata     <= '0;
    end else begin
      state         <= state_n;
      bus_req_valid <= (state_n == REQ);
      out_valid     <= (state_n == DONE);
      out_err       <= err_c;

      if (state == IDLE) begin
        cnt <= '0;
      end else if ((state == REQ) || (state == WAIT)) begin
        cnt <= cnt + CW'(1);
      end

      if ((state == IDLE) && access_c) begin
        bus_req_we    <= in_wen;
        bus_req_addr  <= {in_addr[31:2], 2'b00};
        bus_req_wdata <= wdata_c;
        bus_req_wstrb <= wstrb_c;
        a_lo          <= in_addr[1:0];
        size_q        <= in_size;
        uns_q         <= in_unsigned;
      end

      if (state_n == DONE) begin
        out_rdata <= (err_c || bus_req_we) ? 32'd0 : ext_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu against a spec-level access model (lanes, extension, latency, timeout).
module tb_mem_stage_lsu;

  localparam int unsigned TO = 8;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_ren;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        stall_req;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_ren(in_ren), .in_wen(in_wen),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .stall_req(stall_req), .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: pick the addressed byte/half out of the word and extend it arithmetically
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [31:0] rd,
                                           input logic [1:0] sz, input bit uns);
    longint v;
    int     shift;
    int     bits;
    if (sz == 2'd0) begin
      bits = 8;  shift = 8 * int'(a % 4);
    end else if (sz == 2'd1) begin
      bits = 16; shift = 16 * int'((a / 2) % 2);
    end else begin
      return rd;
    end
    v = (longint'(rd) / (64'sd1 <<< shift)) % (64'sd1 <<< bits);
    if (!uns && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(1 << int'(a % 4));
    if (sz == 2'd1) return 4'(3 << (2 * int'((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit exp_trap(input logic [31:0] a, input logic [1:0] sz);
    return TRAP && (((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0)));
  endfunction

  // kind: 0=load, 1=store, 2=load+store together (acts as store); r/s = ready/response delays
  task automatic run_access(input int kind, input logic [31:0] addr, input logic [31:0] d,
                            input logic [1:0] sz, input bit uns, input int r, input int s,
                            input logic [31:0] rd, input string nm);
    bit          wr   = (kind != 0);
    bit          trap = exp_trap(addr, sz);
    bit          tmo  = !trap && ((r + s + 2 > int'(TO)) || (r + 1 >= int'(TO)));
    int          lat  = trap ? 1 : (tmo ? int'(TO) + 1 : 3 + r + s);
    logic [31:0] xr   = (trap || tmo) ? 32'd0 : exp_load(addr, rd, sz, uns);
    logic [68:0] xf   = {wr, addr & 32'hFFFF_FFFC, wr ? exp_strb(addr, sz) : 4'h0,
                         wr ? exp_wdata(d, sz) : 32'd0};
    bit accepted = 0;
    bit got      = 0;
    int rq = 0;
    int wt = 0;
    int cyc = 0;

    in_addr = addr; in_wdata = d; in_size = sz; in_unsigned = uns;
    in_ren = (kind != 1); in_wen = wr;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({stall_req, bus_req_valid, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s issue: stall/valid/out=%b want 100", nm, {stall_req, bus_req_valid, out_valid});
    end

    while (!got && cyc < 60) begin
      tick();
      cyc++;
      if (bus_req_ready) accepted = 1;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = $urandom;
      if (out_valid) begin
        got = 1;
        checks++;
        if (cyc != lat || out_err !== (trap || tmo) || stall_req !== 1'b0) begin
          errors++;
          $display("FAIL %s done: cycle=%0d err=%b stall=%b want cycle=%0d err=%b stall=0",
                   nm, cyc, out_err, stall_req, lat, trap || tmo);
        end
        if (!wr) begin
          checks++;
          if (out_rdata !== xr) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", nm, out_rdata, xr);
          end
        end
        in_ren = 1'b0;
        in_wen = 1'b0;
      end else if (!accepted) begin
        checks++;
        if ({bus_req_valid, stall_req} !== 2'b11 ||
            {bus_req_we, bus_req_addr, bus_req_wstrb, wr ? bus_req_wdata : 32'd0} !== xf) begin
          errors++;
          $display("FAIL %s req: valid=%b stall=%b fields=%h want 11 %h", nm, bus_req_valid,
                   stall_req, {bus_req_we, bus_req_addr, bus_req_wstrb,
                   wr ? bus_req_wdata : 32'd0}, xf);
        end
        if (rq >= r) bus_req_ready = 1'b1;
        rq++;
      end else begin
        checks++;
        if ({bus_req_valid, stall_req} !== 2'b01) begin
          errors++;
          $display("FAIL %s wait: valid/stall=%b want 01", nm, {bus_req_valid, stall_req});
        end
        if (wt >= s) begin
          bus_rsp_valid = 1'b1;
          bus_rsp_rdata = rd;
        end
        wt++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s no_out_valid: none after %0d cycles, want one at %0d", nm, cyc, lat);
    end
    tick();
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    checks++;
    if ({out_valid, stall_req, bus_req_valid} !== 3'b000) begin
      errors++;
      $display("FAIL %s after: out/stall/valid=%b want 000", nm, {out_valid, stall_req, bus_req_valid});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus_req_valid, stall_req, out_valid, out_err, out_rdata} !== 36'd0) begin
      errors++;
      $display("FAIL reset: valid=%b stall=%b out=%b err=%b rdata=%h want all 0",
               bus_req_valid, stall_req, out_valid, out_err, out_rdata);
    end
    tick();
  endtask

  task automatic test_directed;
    run_access(1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 0, 32'h0, "sw");
    run_access(1, 32'h103, 32'h0000_00AB, 2'd0, 1'b0, 0, 0, 32'h0, "sb");
    run_access(1, 32'h106, 32'h1234_5678, 2'd1, 1'b0, 1, 2, 32'h0, "sh");
    run_access(0, 32'h101, 32'h0, 2'd0, 1'b0, 0, 0, 32'h0000_8000, "lb");
    run_access(0, 32'h101, 32'h0, 2'd0, 1'b1, 0, 0, 32'h0000_8000, "lbu");
    run_access(0, 32'h102, 32'h0, 2'd1, 1'b0, 0, 0, 32'h8001_0000, "lh");
    run_access(0, 32'h102, 32'h0, 2'd1, 1'b1, 0, 1, 32'h8001_0000, "lhu");
    run_access(2, 32'h104, 32'hCAFE_F00D, 2'd3, 1'b0, 0, 0, 32'h0, "ren_wen");
  endtask

  task automatic test_ready_stall;
    run_access(0, 32'h208, 32'h0, 2'd2, 1'b0, 5, 0, 32'h1357_9BDF, "ready_low5");
  endtask

  task automatic test_misalign;
    run_access(0, 32'h102, 32'h0, 2'd2, 1'b0, 0, 0, 32'hA5A5_5A5A, "lw_misalign");
    run_access(0, 32'h301, 32'h0, 2'd1, 1'b0, 0, 0, 32'h00FF_8000, "lh_odd");
  endtask

  task automatic test_timeout;
    run_access(0, 32'h400, 32'h0, 2'd2, 1'b0, 0, 1000, 32'hFFFF_FFFF, "timeout_wait");
    run_access(1, 32'h404, 32'h55, 2'd0, 1'b0, 1000, 0, 32'h0, "timeout_req");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      run_access(int'($urandom_range(0, 2)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_rst_mid;
    int pulses = 0;
    in_addr = 32'h500; in_wdata = 32'h0; in_size = 2'd2; in_unsigned = 1'b0;
    in_ren = 1'b1; in_wen = 1'b0;
    tick();
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    checks++;
    if ({bus_req_valid, stall_req} !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid wait: valid/stall=%b want 01", {bus_req_valid, stall_req});
    end
    rst = 1'b1;
    in_ren = 1'b0;
    tick();
    rst = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus_rsp_valid = 1'b0;
      if (out_valid || stall_req || bus_req_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_mid late_rsp: %0d active cycles want 0", pulses);
    end
    run_access(0, 32'h504, 32'h0, 2'd0, 1'b1, 0, 0, 32'hAABB_CCDD, "after_rst");
  endtask

  initial begin
    rst = 1'b1;
    in_addr = '0; in_wdata = '0; in_ren = 1'b0; in_wen = 1'b0;
    in_size = '0; in_unsigned = 1'b0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    test_reset();
    test_directed();
    test_ready_stall();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
